// File: rtl/image_stream_pkg.sv
// Shared definitions for the image byte stream (serializer and parser sides).
// CHECKSUM_EN adds the trailing XOR checksum state.
package image_stream_pkg;

    localparam int HDR_BYTES       = 4;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int DIM_W           = 16;
    localparam int CHAN_W          = 8;
    localparam int NPIX_W          = 32;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WAIT_PIX,
        SEND_R,
        SEND_G,
        SEND_B,
`ifdef CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    // Header order on the wire: height LSB, height MSB, width LSB, width MSB.
    function automatic logic [CHAN_W-1:0] hdr_byte(input logic [1:0] idx,
                                                   input logic [DIM_W-1:0] h,
                                                   input logic [DIM_W-1:0] w);
        logic [CHAN_W-1:0] b;
        b = h[7:0];
        case (idx)
            2'd0:    b = h[7:0];
            2'd1:    b = h[15:8];
            2'd2:    b = w[7:0];
            default: b = w[15:8];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/pixel_down_counter.sv
// Remaining-pixel counter: loads height*width, counts down once per sent pixel.
module pixel_down_counter
    import image_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [NPIX_W-1:0] load_value,
    input  logic              dec,
    output logic              is_zero,
    output logic              is_one
);

    logic [NPIX_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign is_zero = (count_reg == '0);
    assign is_one  = (count_reg == NPIX_W'(1));

endmodule

// File: rtl/image_serializer.sv
// Serializes a frame as height/width header followed by R,G,B bytes per pixel.
// Optional macro CHECKSUM_EN appends one XOR byte over the whole stream.
module image_serializer
    import image_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DIM_W-1:0]  height,
    input  logic [DIM_W-1:0]  width,
    input  logic [CHAN_W-1:0] pix_r,
    input  logic [CHAN_W-1:0] pix_g,
    input  logic [CHAN_W-1:0] pix_b,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic [CHAN_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    state_t            state_reg, state_next;
    logic [1:0]        hdr_idx_reg, hdr_idx_next;
    logic [DIM_W-1:0]  height_reg, height_next;
    logic [DIM_W-1:0]  width_reg, width_next;
    logic [CHAN_W-1:0] g_reg, g_next;
    logic [CHAN_W-1:0] b_reg, b_next;
    logic [CHAN_W-1:0] data_out_reg, data_out_next;
    logic              out_valid_reg, out_valid_next;
    logic              pix_ready_reg, pix_ready_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
`ifdef CHECKSUM_EN
    logic [CHAN_W-1:0] csum_reg, csum_next;
`endif

    logic              out_xfer;
    logic              pix_xfer;
    logic              end_frame;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_is_zero;
    logic              cnt_is_one;
    logic [NPIX_W-1:0] npix_product;

    assign out_xfer     = out_valid_reg & out_ready;
    assign pix_xfer     = pix_valid & pix_ready_reg;
    assign npix_product = NPIX_W'(height) * NPIX_W'(width);

    pixel_down_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (npix_product),
        .dec        (cnt_dec),
        .is_zero    (cnt_is_zero),
        .is_one     (cnt_is_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            hdr_idx_reg   <= '0;
            height_reg    <= '0;
            width_reg     <= '0;
            g_reg         <= '0;
            b_reg         <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            pix_ready_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            hdr_idx_reg   <= hdr_idx_next;
            height_reg    <= height_next;
            width_reg     <= width_next;
            g_reg         <= g_next;
            b_reg         <= b_next;
            data_out_reg  <= data_out_next;
            out_valid_reg <= out_valid_next;
            pix_ready_reg <= pix_ready_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
`ifdef CHECKSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        hdr_idx_next   = hdr_idx_reg;
        height_next    = height_reg;
        width_next     = width_reg;
        g_next         = g_reg;
        b_next         = b_reg;
        data_out_next  = data_out_reg;
        out_valid_next = out_valid_reg;
        pix_ready_next = pix_ready_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        end_frame      = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
`ifdef CHECKSUM_EN
        csum_next = csum_reg;
        if (out_xfer && (state_reg != CSUM)) begin
            csum_next = csum_reg ^ data_out_reg;
        end
`endif

        case (state_reg)
            IDLE: begin
                if (start) begin
                    height_next    = height;
                    width_next     = width;
                    cnt_load       = 1'b1;
                    busy_next      = 1'b1;
                    hdr_idx_next   = 2'd0;
                    out_valid_next = 1'b1;
                    data_out_next  = height[7:0];
                    state_next     = HDR;
`ifdef CHECKSUM_EN
                    csum_next      = '0;
`endif
                end
            end
            HDR: begin
                if (out_xfer) begin
                    if (hdr_idx_reg == 2'(HDR_BYTES - 1)) begin
                        if (cnt_is_zero) begin
                            end_frame = 1'b1;
                        end else begin
                            out_valid_next = 1'b0;
                            pix_ready_next = 1'b1;
                            state_next     = WAIT_PIX;
                        end
                    end else begin
                        hdr_idx_next  = hdr_idx_reg + 2'd1;
                        data_out_next = hdr_byte(hdr_idx_reg + 2'd1, height_reg, width_reg);
                    end
                end
            end
            WAIT_PIX: begin
                if (pix_xfer) begin
                    g_next         = pix_g;
                    b_next         = pix_b;
                    pix_ready_next = 1'b0;
                    out_valid_next = 1'b1;
                    data_out_next  = pix_r;
                    state_next     = SEND_R;
                end
            end
            SEND_R: begin
                if (out_xfer) begin
                    data_out_next = g_reg;
                    state_next    = SEND_G;
                end
            end
            SEND_G: begin
                if (out_xfer) begin
                    data_out_next = b_reg;
                    state_next    = SEND_B;
                end
            end
            SEND_B: begin
                if (out_xfer) begin
                    cnt_dec = 1'b1;
                    // is_one is sampled before the decrement lands, so it marks the last pixel.
                    if (cnt_is_one) begin
                        end_frame = 1'b1;
                    end else begin
                        out_valid_next = 1'b0;
                        pix_ready_next = 1'b1;
                        state_next     = WAIT_PIX;
                    end
                end
            end
`ifdef CHECKSUM_EN
            CSUM: begin
                if (out_xfer) begin
                    out_valid_next = 1'b0;
                    busy_next      = 1'b0;
                    done_next      = 1'b1;
                    state_next     = DONE;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (end_frame) begin
`ifdef CHECKSUM_EN
            out_valid_next = 1'b1;
            data_out_next  = csum_next;
            state_next     = CSUM;
`else
            out_valid_next = 1'b0;
            busy_next      = 1'b0;
            done_next      = 1'b1;
            state_next     = DONE;
`endif
        end
    end

    assign data_out  = data_out_reg;
    assign out_valid = out_valid_reg;
    assign pix_ready = pix_ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_image_serializer.sv
// Directed bench for image_serializer; define CHECKSUM_EN to expect the trailing XOR byte.
module tb_image_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] height;
    logic [15:0] width;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  data_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    image_serializer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .height    (height),
        .width     (width),
        .pix_r     (pix_r),
        .pix_g     (pix_g),
        .pix_b     (pix_b),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [23:0] pix_q[$];
    logic [7:0]  got[$];
    int          done_cnt;
    int          stall_err;
    int          k;
    bit          pr_seen;
    logic        busy_at_done;
    logic        post_done_bad;

    task automatic send_start(input logic [15:0] h, input logic [15:0] w);
        @(negedge clk);
        height = h;
        width  = w;
        start  = 1'b1;
    endtask

    // Runs the handshakes cycle by cycle from the negedge; stops on done or after max_bytes.
    task automatic collect(input int max_bytes, input bit rand_ready, input int restart_at);
        bit         hold = 1'b0;
        logic [7:0] held = 8'h00;
        bit         restarted = 1'b0;
        got.delete();
        done_cnt = 0; stall_err = 0; k = 0; pr_seen = 1'b0;
        busy_at_done = 1'b1; post_done_bad = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (hold && (!out_valid || data_out !== held)) stall_err++;
            if (pix_ready) pr_seen = 1'b1;
            if (done) begin
                done_cnt++;
                busy_at_done = busy;
                out_ready = 1'b0; pix_valid = 1'b0;
                start = 1'b1; height = 16'd7; width = 16'd7;
                @(negedge clk);
                start = 1'b0;
                post_done_bad = done | busy | out_valid;
                return;
            end
            if (got.size() >= max_bytes) begin
                out_ready = 1'b0; pix_valid = 1'b0;
                return;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) got.push_back(data_out);
            hold = out_valid && !out_ready;
            held = data_out;
            if (k < pix_q.size()) begin
                pix_valid = 1'b1;
                {pix_r, pix_g, pix_b} = pix_q[k];
                if (pix_ready) k++;
            end else begin
                pix_valid = 1'b0;
            end
            if (restart_at >= 0 && !restarted && got.size() == restart_at) begin
                start = 1'b1; height = 16'h0909; width = 16'h0909;
                restarted = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({data_out, out_valid, pix_ready, busy, done} !== 12'h000) begin
            $display("FAIL reset_outputs: got data=%h valid=%b pix_ready=%b busy=%b done=%b, want all 0",
                     data_out, out_valid, pix_ready, busy, done);
        end else passes++;
        $display("reset: data=%h valid=%b pix_ready=%b busy=%b done=%b",
                 data_out, out_valid, pix_ready, busy, done);
    endtask

    task automatic test_basic_frame(input string name, input bit rand_ready);
        logic [7:0] exp[$] = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] g;
`ifdef CHECKSUM_EN
        exp.push_back(8'h74);
`endif
        pix_q = '{24'h112233, 24'h445566};
        send_start(16'd2, 16'd1);
        collect(100, rand_ready, -1);
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            checks++;
            if (g !== exp[i]) $display("FAIL %s_byte%0d: got %h want %h", name, i, g, exp[i]);
            else passes++;
            $display("%s byte %0d: %h", name, i, g);
        end
        checks++;
        if (got.size() !== exp.size()) $display("FAIL %s_len: got %0d want %0d", name, got.size(), exp.size());
        else passes++;
        checks++;
        if (done_cnt !== 1) $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt);
        else passes++;
        checks++;
        if (busy_at_done !== 1'b0) $display("FAIL %s_busy_at_done: got %b want 0", name, busy_at_done);
        else passes++;
        checks++;
        if (post_done_bad !== 1'b0) $display("FAIL %s_after_done: got done|busy|valid=%b want 0 (start in DONE ignored)", name, post_done_bad);
        else passes++;
        checks++;
        if (stall_err !== 0) $display("FAIL %s_stable: got %0d unstable stalls want 0", name, stall_err);
        else passes++;
    endtask

    task automatic test_zero_size();
        logic [7:0] exp[$] = '{8'h05, 8'h00, 8'h00, 8'h00};
        logic [7:0] g;
`ifdef CHECKSUM_EN
        exp.push_back(8'h05);
`endif
        pix_q.delete();
        send_start(16'd5, 16'd0);
        collect(100, 1'b0, -1);
        for (int i = 0; i < exp.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            checks++;
            if (g !== exp[i]) $display("FAIL zero_byte%0d: got %h want %h", i, g, exp[i]);
            else passes++;
            $display("zero byte %0d: %h", i, g);
        end
        checks++;
        if (got.size() !== exp.size()) $display("FAIL zero_len: got %0d want %0d", got.size(), exp.size());
        else passes++;
        checks++;
        if (pr_seen !== 1'b0) $display("FAIL zero_pix_ready: got %b want 0", pr_seen);
        else passes++;
        checks++;
        if (done_cnt !== 1) $display("FAIL zero_done: got %0d pulses want 1", done_cnt);
        else passes++;
    endtask

    task automatic test_start_while_busy();
        logic [7:0] exp[4] = '{8'h02, 8'h01, 8'h04, 8'h03};
        logic [7:0] g;
        pix_q.delete();
        send_start(16'h0102, 16'h0304);
        collect(4, 1'b0, 2);
        for (int i = 0; i < 4; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            checks++;
            if (g !== exp[i]) $display("FAIL busy_hdr%0d: got %h want %h", i, g, exp[i]);
            else passes++;
            $display("busy-start header %0d: %h", i, g);
        end
        checks++;
        if ({pix_ready, out_valid, busy} !== 3'b101)
            $display("FAIL busy_wait_pix: got pix_ready/valid/busy=%b%b%b want 101", pix_ready, out_valid, busy);
        else passes++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        pix_q = '{24'h112233, 24'h445566};
        send_start(16'd2, 16'd1);
        collect(5, 1'b0, -1);
        checks++;
        if ({out_valid, data_out} !== {1'b1, 8'h22})
            $display("FAIL rst_in_send_g: got valid=%b data=%h want 1 22", out_valid, data_out);
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, pix_ready} !== 3'b000)
            $display("FAIL rst_async: got valid/busy/pix_ready=%b%b%b want 000", out_valid, busy, pix_ready);
        else passes++;
        $display("async reset: valid=%b busy=%b", out_valid, busy);
        @(negedge clk);
        reset = 1'b0;
        test_basic_frame("after_reset", 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; height = '0; width = '0;
        pix_r = '0; pix_g = '0; pix_b = '0; pix_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_basic_frame("basic", 1'b0);
        test_basic_frame("stall", 1'b1);
        test_zero_size();
        test_start_while_busy();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
